// File: rtl/vga_pic_disp_gen.sv
// VGA timing generator with a ROM-backed picture window and an optional per-frame bounce.
// Control signals are delayed ROM_LAT+1 clocks so they line up with the synchronous ROM data.
module vga_pic_disp_gen #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 600,
    parameter int unsigned V_FP     = 1,
    parameter int unsigned V_SYNC   = 4,
    parameter int unsigned V_BP     = 23,
    parameter bit          SYNC_POL = 1'b1,
    parameter int unsigned PIC_W    = 100,
    parameter int unsigned PIC_H    = 100,
    parameter int unsigned ADDR_W   = 14,
    parameter int unsigned RGB_W    = 8,
    parameter int unsigned ROM_LAT  = 1,
    parameter logic [RGB_W-1:0] BG_COLOR = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [11:0]       pic_x,
    input  logic [11:0]       pic_y,
    input  logic              move_en,
    input  logic [RGB_W-1:0]  rom_q,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [RGB_W-1:0]  vga_rgb,
    output logic              frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int unsigned X_LIM    = H_ACTIVE - PIC_W;
    localparam int unsigned Y_LIM    = V_ACTIVE - PIC_H;
    localparam int unsigned DLY      = ROM_LAT + 1;

    // Pipeline word: {frame_start, hs, vs, de, hit}
    localparam logic [4:0] PIPE_RST = {1'b0, ~SYNC_POL, ~SYNC_POL, 1'b0, 1'b0};

    logic [11:0]       h_cnt_q, v_cnt_q;
    logic [11:0]       px_q, py_q;
    logic              dx_q, dy_q;
    logic [ADDR_W-1:0] row_base_q;
    logic [ADDR_W-1:0] rom_addr_q;
    logic [4:0]        pipe_q [DLY];

    logic        h_wrap, v_wrap, fs_raw;
    logic [12:0] bx, by;
    logic [11:0] nx_px, nx_py;
    logic        nx_dx, nx_dy;
    logic [11:0] cur_px, cur_py;
    logic        h_win, v_win, h_act, v_act;
    logic        hs_raw, vs_raw, de_raw, hit_raw;

    // Returns {dir, pos}; reverses at either edge instead of stepping past it.
    function automatic logic [12:0] bounce(input logic [11:0] pos, input logic dir,
                                           input logic [11:0] lim);
        logic [12:0] r;
        if (dir) begin
            if (pos < lim)          r = {1'b1, pos + 12'd1};
            else if (pos == 12'd0)  r = {1'b1, pos};
            else                    r = {1'b0, pos - 12'd1};
        end else begin
            if (pos != 12'd0)       r = {1'b0, pos - 12'd1};
            else if (lim != 12'd0)  r = {1'b1, 12'd1};
            else                    r = {1'b1, pos};
        end
        return r;
    endfunction

    always_comb begin
        h_wrap = (h_cnt_q == 12'(H_TOTAL - 1));
        v_wrap = (v_cnt_q == 12'(V_TOTAL - 1));
        fs_raw = (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);

        bx = bounce(px_q, dx_q, 12'(X_LIM));
        by = bounce(py_q, dy_q, 12'(Y_LIM));
        nx_px = move_en ? bx[11:0] : pic_x;
        nx_py = move_en ? by[11:0] : pic_y;
        nx_dx = move_en ? bx[12] : dx_q;
        nx_dy = move_en ? by[12] : dy_q;

        // The new position applies from the frame-start pixel itself.
        cur_px = fs_raw ? nx_px : px_q;
        cur_py = fs_raw ? nx_py : py_q;

        h_act = (h_cnt_q < 12'(H_ACTIVE));
        v_act = (v_cnt_q < 12'(V_ACTIVE));
        h_win = ({1'b0, h_cnt_q} >= {1'b0, cur_px}) &&
                ({1'b0, h_cnt_q} <  ({1'b0, cur_px} + 13'(PIC_W)));
        v_win = ({1'b0, v_cnt_q} >= {1'b0, cur_py}) &&
                ({1'b0, v_cnt_q} <  ({1'b0, cur_py} + 13'(PIC_H)));

        hs_raw  = ((h_cnt_q >= 12'(HS_START)) && (h_cnt_q < 12'(HS_END))) ? SYNC_POL : ~SYNC_POL;
        vs_raw  = ((v_cnt_q >= 12'(VS_START)) && (v_cnt_q < 12'(VS_END))) ? SYNC_POL : ~SYNC_POL;
        de_raw  = h_act && v_act;
        hit_raw = h_win && v_win && h_act && v_act;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_wrap ? 12'd0 : h_cnt_q + 12'd1;
            if (h_wrap) begin
                v_cnt_q <= v_wrap ? 12'd0 : v_cnt_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            px_q <= '0;
            py_q <= '0;
            dx_q <= 1'b1;
            dy_q <= 1'b1;
        end else if (fs_raw) begin
            px_q <= nx_px;
            py_q <= nx_py;
            dx_q <= nx_dx;
            dy_q <= nx_dy;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_base_q <= '0;
            rom_addr_q <= '0;
        end else begin
            if (h_wrap) begin
                if (v_wrap)     row_base_q <= '0;
                else if (v_win) row_base_q <= row_base_q + ADDR_W'(PIC_W);
            end
            if (hit_raw) begin
                rom_addr_q <= row_base_q + ADDR_W'(h_cnt_q - cur_px);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DLY); i++) pipe_q[i] <= PIPE_RST;
        end else begin
            pipe_q[0] <= {fs_raw, hs_raw, vs_raw, de_raw, hit_raw};
            for (int i = 1; i < int'(DLY); i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign rom_addr    = rom_addr_q;
    assign frame_start = pipe_q[DLY-1][4];
    assign vga_hs      = pipe_q[DLY-1][3];
    assign vga_vs      = pipe_q[DLY-1][2];
    assign vga_de      = pipe_q[DLY-1][1];

    // rom_q is already a registered ROM output, so this mux keeps the pin latency at ROM_LAT+1.
    always_comb begin
        if (pipe_q[DLY-1][0])      vga_rgb = rom_q;
        else if (pipe_q[DLY-1][1]) vga_rgb = BG_COLOR;
        else                       vga_rgb = '0;
    end

endmodule

// File: tb/tb_vga_pic_disp_gen.sv
// Directed bench for vga_pic_disp_gen on a shrunken 24x17 raster with a 4x3 picture.
// Pixel positions are addressed relative to the frame_start pulse seen at the pins.
module tb_vga_pic_disp_gen;

    localparam int HT = 24;
    localparam int VT = 17;
    localparam int FRAME = HT * VT;
    localparam logic [7:0] BG = 8'hAA;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] pic_x, pic_y;
    logic        move_en;
    logic [7:0]  rom_q = 8'h00;
    logic [7:0]  rom_addr;
    logic        vga_hs, vga_vs, vga_de, frame_start;
    logic [7:0]  vga_rgb;

    int checks = 0;
    int errors = 0;
    int pos = 0;
    int n, old;

    vga_pic_disp_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .SYNC_POL(1'b1), .PIC_W(4), .PIC_H(3), .ADDR_W(8), .RGB_W(8),
        .ROM_LAT(1), .BG_COLOR(BG)
    ) dut (
        .clk(clk), .rst(rst), .pic_x(pic_x), .pic_y(pic_y), .move_en(move_en),
        .rom_q(rom_q), .rom_addr(rom_addr), .vga_hs(vga_hs), .vga_vs(vga_vs),
        .vga_de(vga_de), .vga_rgb(vga_rgb), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // One-clock-latency ROM whose word is the low address byte.
    always @(posedge clk) rom_q <= rom_addr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fs(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!frame_start && cnt < 2000);
        if (!frame_start) chk("fs_timeout", frame_start, 1);
        pos = 0;
    endtask

    task automatic at(input int h, input int v);
        int target;
        target = v * HT + h;
        while (pos < target) begin
            @(negedge clk);
            pos++;
        end
    endtask

    task automatic next_frame(input string tag);
        old = pos;
        wait_fs(n);
        chk(tag, old + n, FRAME);
    endtask

    initial begin
        rst = 1'b1; pic_x = 12'd0; pic_y = 12'd0; move_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_hs", vga_hs, 0);
        chk("rst_vs", vga_vs, 0);
        chk("rst_de", vga_de, 0);
        chk("rst_rgb", vga_rgb, 0);
        chk("rst_fs", frame_start, 0);
        chk("rst_addr", rom_addr, 0);

        rst = 1'b0;
        wait_fs(n);
        chk("fs_latency", n, 2);
        // Frame 1: picture at (0,0)
        chk("f1_de0", vga_de, 1);
        at(3, 0);   chk("f1_px3", vga_rgb, 8'h03);
        at(4, 0);   chk("f1_px4_bg", vga_rgb, BG);
        at(15, 0);  chk("f1_px15_bg", vga_rgb, BG);
        at(16, 0);  chk("f1_blank_de", vga_de, 0);
                    chk("f1_blank_rgb", vga_rgb, 0);
        at(17, 0);  chk("f1_hs17", vga_hs, 0);
        at(18, 0);  chk("f1_hs18", vga_hs, 1);
        at(20, 0);  chk("f1_hs20", vga_hs, 1);
        at(21, 0);  chk("f1_hs21", vga_hs, 0);
        at(0, 1);   chk("f1_l1p0", vga_rgb, 8'h04);
        at(3, 2);   chk("f1_l2p3", vga_rgb, 8'h0B);
        at(0, 3);   chk("f1_l3_bg", vga_rgb, BG);
        at(0, 12);  chk("f1_vs12", vga_vs, 0);
        at(0, 13);  chk("f1_vs13", vga_vs, 1);
        at(23, 14); chk("f1_vs14", vga_vs, 1);
        at(0, 15);  chk("f1_vs15", vga_vs, 0);
        pic_x = 12'd14; pic_y = 12'd10;
        next_frame("f1_len");

        // Frame 2: clipped at the right and bottom edges; new position requested mid-frame
        at(5, 5);   pic_x = 12'd2; pic_y = 12'd1;
        at(13, 10); chk("f2_left_bg", vga_rgb, BG);
        at(15, 10); chk("f2_r0", vga_rgb, 8'h01);
        at(0, 11);  chk("f2_nowrap", vga_rgb, BG);
        at(14, 11); chk("f2_r1c0", vga_rgb, 8'h04);
        at(15, 11); chk("f2_r1c1", vga_rgb, 8'h05);
        at(16, 11); chk("f2_clip_rgb", vga_rgb, 0);
        at(14, 12); chk("f2_clip_de", vga_de, 0);
        next_frame("f2_len");

        // Frame 3: position (2,1) applied at the frame boundary
        at(2, 0);   chk("f3_l0_bg", vga_rgb, BG);
        at(1, 1);   chk("f3_left_bg", vga_rgb, BG);
        at(3, 1);   chk("f3_r0c1", vga_rgb, 8'h01);
        at(2, 2);   chk("f3_r1c0", vga_rgb, 8'h04);
        at(5, 3);   chk("f3_r2c3", vga_rgb, 8'h0B);
        at(2, 4);   chk("f3_below_bg", vga_rgb, BG);
        at(14, 10); chk("f3_old_bg", vga_rgb, BG);
        pic_x = 12'd20; pic_y = 12'd0;
        next_frame("f3_len");

        // Frame 4: off-screen position, whole active area is background
        at(0, 0);   chk("f4_bg0", vga_rgb, BG);
        at(15, 0);  chk("f4_bg15", vga_rgb, BG);
        at(3, 1);   chk("f4_bg_l1", vga_rgb, BG);
        pic_x = 12'd10;
        wait_fs(n);

        // Frame 5: static (10,0), then bounce enabled
        at(9, 1);   chk("f5_left_bg", vga_rgb, BG);
        at(10, 1);  chk("f5_r1c0", vga_rgb, 8'h04);
        move_en = 1'b1;
        wait_fs(n);
        at(10, 2);  chk("f6_left_bg", vga_rgb, BG);
        at(11, 2);  chk("f6_r1c0", vga_rgb, 8'h04);
        wait_fs(n);
        at(11, 3);  chk("f7_left_bg", vga_rgb, BG);
        at(12, 3);  chk("f7_r1c0", vga_rgb, 8'h04);
        at(15, 3);  chk("f7_r1c3", vga_rgb, 8'h07);
        wait_fs(n);
        at(10, 4);  chk("f8_left_bg", vga_rgb, BG);
        at(11, 4);  chk("f8_flip_r1c0", vga_rgb, 8'h04);
        at(12, 4);  chk("f8_flip_r1c1", vga_rgb, 8'h05);
        at(15, 4);  chk("f8_right_bg", vga_rgb, BG);
        move_en = 1'b0; pic_x = 12'd0; pic_y = 12'd0;
        wait_fs(n);

        // Frame 9: reload from pins, then a mid-frame reset
        at(0, 1);   chk("f9_reload", vga_rgb, 8'h04);
        at(2, 5);   chk("f9_de_pre", vga_de, 1);
        rst = 1'b1;
        #1;
        chk("mrst_de", vga_de, 0);
        chk("mrst_rgb", vga_rgb, 0);
        chk("mrst_hs", vga_hs, 0);
        chk("mrst_vs", vga_vs, 0);
        chk("mrst_fs", frame_start, 0);
        chk("mrst_addr", rom_addr, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_fs(n);
        chk("mrst_fs_latency", n, 2);
        at(3, 0);   chk("mrst_px3", vga_rgb, 8'h03);
        at(18, 0);  chk("mrst_hs18", vga_hs, 1);
        at(21, 0);  chk("mrst_hs21", vga_hs, 0);
        next_frame("mrst_len");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
